md_issue_ctrl: RTL and testbench
================================

Name: md_issue_ctrl

Overview:
E-stage initiator for the multiply/divide unit. It takes decoded mult/multu/div/divu/mthi/mtlo/mfhi/mflo from the E stage and drives the unit's start, opcode, operand and move-to strobes. It tracks the unit's busy handshake in a small FSM and raises the E-stage stall for any later HI/LO-class instruction. It muxes HI/LO for mfhi/mflo and checks that busy latency matches the contract, setting a sticky error if it does not.

Parameters:
MULT_LAT, 5, required busy-high cycles for mult/multu
DIV_LAT, 10, required busy-high cycles for div/divu
CNT_W, 4, width of the busy-duration counter; must hold DIV_LAT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
e_md_valid  in  1  E stage holds mult/multu/div/divu
e_md_op  in  3  op code, encoded with `mult/`multu/`div/`divu
e_mthi  in  1  E stage holds mthi
e_mtlo  in  1  E stage holds mtlo
e_mfhi  in  1  E stage holds mfhi
e_mflo  in  1  E stage holds mflo
e_rs  in  32  forwarded rs value
e_rt  in  32  forwarded rt value
flush  in  1  exception/interrupt kills E-stage instruction this cycle
md_busy  in  1  busy from the mult/div unit
md_hi  in  32  HI from the unit
md_lo  in  32  LO from the unit
md_start  out  1  start strobe to the unit
md_op  out  3  op to the unit (e_md_op passthrough)
md_mthi  out  1  mthi strobe to the unit
md_mtlo  out  1  mtlo strobe to the unit
md_a  out  32  operand A (e_rs)
md_b  out  32  operand B (e_rt)
stall_e  out  1  freeze F/D/E and bubble M
mf_data  out  32  mfhi/mflo result for E-stage forwarding
md_err  out  1  sticky latency/handshake violation

Behaviour:
- md_class = e_md_valid | e_mthi | e_mtlo | e_mfhi | e_mflo.
- FSM states: IDLE, RUN. Reset (reset=0, asynchronous) sets IDLE, clears the counter, clears exp_lat, and clears md_err.
- stall_e = md_class & (md_busy | state==RUN & first_run_cycle). It is combinational. A busy-fall cycle does not stall.
- issue = e_md_valid & ~stall_e & ~flush. md_start = issue. md_mthi = e_mthi & ~stall_e & ~flush. md_mtlo = e_mtlo & ~stall_e & ~flush. All three are combinational and at most one is high.
- md_op, md_a and md_b are always driven from the E-stage inputs. Outputs are all-zero strobes whenever reset is low.
- IDLE -> RUN on an issue edge. exp_lat is latched: MULT_LAT for mult/multu, DIV_LAT for div/divu. The counter is cleared.
- RUN: while md_busy=1 the counter increments, saturating at all-ones.
- RUN -> IDLE on the edge where md_busy=0. If the counter != exp_lat, md_err is set.
- RUN, first cycle: md_busy must be 1. If it is 0, md_err is set and the FSM returns to IDLE.
- IDLE with md_busy=1 sets md_err.
- Once started, an op is never cancelled. A flush after issue does not affect the unit, and a later flush only suppresses that cycle's strobes.
- flush during a stall: strobes are already 0. The stall still reflects md_busy.
- mf_data = e_mfhi ? md_hi : e_mflo ? md_lo : 32'b0.
- mfhi in the cycle right after mthi reads the new value, because the unit updates HI at that edge. No stall is needed.
- Unknown e_md_op with e_md_valid issues nothing, sets md_err, and leaves the FSM in IDLE.

Optional Feature:
- MD_DIV0_SKIP_EN defined: div/divu with e_rt==0 is treated as issued but md_start stays 0. The FSM stays IDLE, HI/LO are unchanged, there is no stall, and md_err is not set.
- Undefined: div-by-zero issues normally. HI/LO contents are architecturally undefined, and latency is still checked.

Decomposition:
- The shared constants.v holds the `mult/`multu/`div/`divu op codes and the FSM state encodings (MD_IDLE, MD_RUN).
- One sub-module is natural: md_lat_checker (counter, exp_lat, md_err). The FSM and strobes stay in md_issue_ctrl.

Test Plan:
- mult, rs=7, rt=-3, then mflo next cycle: md_start high 1 cycle, stall_e high 5 cycles, then mf_data=32'hFFFF_FFEB, md_hi=32'hFFFF_FFFF, md_err=0.
- divu, rs=100, rt=7, then back-to-back multu: multu stalled 10 cycles and issued on the busy-fall cycle; LO=14, HI=2.
- mthi rs=32'hDEAD_BEEF, then mfhi: md_mthi high 1 cycle, no stall, mf_data=32'hDEAD_BEEF.
- mult with flush=1 in the issue cycle: md_start=0, FSM stays IDLE, next mflo returns the old LO.
- Busy model held 4 cycles for mult: md_err=1 after busy fall and stays 1 until reset=0. Asserting reset mid-RUN returns IDLE immediately.
- div, rt=0: with MD_DIV0_SKIP_EN, md_start=0 and stall_e=0. Without it, md_start=1 and 10 busy cycles.

Source files
------------

// File: rtl/md_issue_ctrl_pkg.sv
// Shared op codes, FSM state encoding and decode helpers for the mult/div issue controller.
package md_issue_ctrl_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    function automatic logic op_known(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_issue_ctrl_if.sv
// E-stage request / mult-div unit handshake bundle; slave is the issue controller, master the surrounding pipe.
interface md_issue_ctrl_if;
    logic        e_md_valid;
    logic [2:0]  e_md_op;
    logic        e_mthi;
    logic        e_mtlo;
    logic        e_mfhi;
    logic        e_mflo;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        flush;
    logic        md_busy;
    logic [31:0] md_hi;
    logic [31:0] md_lo;
    logic        md_start;
    logic [2:0]  md_op;
    logic        md_mthi;
    logic        md_mtlo;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        stall_e;
    logic [31:0] mf_data;
    logic        md_err;

    modport slave (
        input  e_md_valid, e_md_op, e_mthi, e_mtlo, e_mfhi, e_mflo, e_rs, e_rt, flush,
        input  md_busy, md_hi, md_lo,
        output md_start, md_op, md_mthi, md_mtlo, md_a, md_b, stall_e, mf_data, md_err
    );

    modport master (
        output e_md_valid, e_md_op, e_mthi, e_mtlo, e_mfhi, e_mflo, e_rs, e_rt, flush,
        output md_busy, md_hi, md_lo,
        input  md_start, md_op, md_mthi, md_mtlo, md_a, md_b, stall_e, mf_data, md_err
    );
endinterface

// File: rtl/md_issue_ctrl_lat_checker.sv
// md_lat_checker: counts busy cycles of the running op and flags any deviation from the
// contracted latency (or a busy/handshake violation) in a sticky error flop.
module md_lat_checker #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic div_op,
    input  logic run,
    input  logic first,
    input  logic busy,
    input  logic bad_op,
    output logic err
);

    localparam logic [CNT_W-1:0] MULT_L = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_L  = CNT_W'(DIV_LAT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] exp_lat_q, exp_lat_d;
    logic             err_q, err_d;

    always_comb begin
        cnt_d     = cnt_q;
        exp_lat_d = exp_lat_q;
        if (start) begin
            cnt_d     = '0;
            exp_lat_d = div_op ? DIV_L : MULT_L;
        end else if (run && busy && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Busy falling ends the op: on the first RUN cycle that is a missing handshake,
        // later it is a latency check. Busy while idle is never legal.
        err_d = err_q | bad_op | (~run & busy)
                      | (run & ~busy & (first | (cnt_q != exp_lat_q)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            exp_lat_q <= '0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            exp_lat_q <= exp_lat_d;
            err_q     <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage initiator for the mult/div unit: strobes, HI/LO-class stall, mfhi/mflo mux, busy FSM.
// Optional MD_DIV0_SKIP_EN: div/divu by zero retires without starting the unit.
module md_issue_ctrl
    import md_issue_ctrl_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic           clk,
    input  logic           reset,
    md_issue_ctrl_if.slave bus
);

    md_state_e state_q, state_d;
    logic      first_q, first_d;
    logic      md_class, stall, gate, op_ok, div_op, div0_skip, issue, start, bad_op, run;

    always_comb begin
        md_class = bus.e_md_valid | bus.e_mthi | bus.e_mtlo | bus.e_mfhi | bus.e_mflo;
        // The first RUN cycle stalls even if busy is late, so nothing slips past a fresh op.
        stall    = md_class & (bus.md_busy | ((state_q == MD_RUN) & first_q));
        gate     = reset & ~stall & ~bus.flush;
        op_ok    = op_known(bus.e_md_op);
        div_op   = op_is_div(bus.e_md_op);
`ifdef MD_DIV0_SKIP_EN
        div0_skip = div_op & (bus.e_rt == '0);
`else
        div0_skip = 1'b0;
`endif
        issue    = bus.e_md_valid & op_ok & gate;
        start    = issue & ~div0_skip;
        bad_op   = bus.e_md_valid & ~op_ok & gate;
        run      = (state_q == MD_RUN);
    end

    // A new op may issue on the busy-fall cycle, so RUN can chain straight into RUN.
    always_comb begin
        state_d = state_q;
        first_d = start;
        case (state_q)
            MD_IDLE: if (start) state_d = MD_RUN;
            MD_RUN:  if (!bus.md_busy) state_d = start ? MD_RUN : MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MD_IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
        end
    end

    md_lat_checker #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_lat (
        .clk    (clk),
        .rst_n  (reset),
        .start  (start),
        .div_op (div_op),
        .run    (run),
        .first  (first_q),
        .busy   (bus.md_busy),
        .bad_op (bad_op),
        .err    (bus.md_err)
    );

    assign bus.md_start = start;
    assign bus.md_mthi  = bus.e_mthi & gate;
    assign bus.md_mtlo  = bus.e_mtlo & gate;
    assign bus.md_op    = bus.e_md_op;
    assign bus.md_a     = bus.e_rs;
    assign bus.md_b     = bus.e_rt;
    assign bus.stall_e  = stall;
    assign bus.mf_data  = bus.e_mfhi ? bus.md_hi : (bus.e_mflo ? bus.md_lo : 32'b0);

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a behavioural mult/div unit model driving busy/HI/LO.
module tb_md_issue_ctrl;
    import md_issue_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    md_issue_ctrl_if ifc();

    md_issue_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int tests = 0;
    int fails = 0;

    // Unit model: busy for the op's latency after md_start, results land on the last busy edge.
    logic [3:0]  bcnt = 4'd0;
    int          lat_ov = 0;
    logic [31:0] hi = 32'd0, lo = 32'd0;
    logic [63:0] pend = 64'd0;

    assign ifc.md_busy = (bcnt != 4'd0);
    assign ifc.md_hi   = hi;
    assign ifc.md_lo   = lo;

    function automatic logic [63:0] unit_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (op)
            OP_MULT: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return sp;
            end
            OP_MULTU: return {32'b0, a} * {32'b0, b};
            OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            OP_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcnt <= 4'd0;
        end else if (ifc.md_start) begin
            bcnt <= (lat_ov != 0) ? 4'(lat_ov) : ((ifc.md_op == OP_DIV || ifc.md_op == OP_DIVU) ? 4'd10 : 4'd5);
            pend <= unit_res(ifc.md_op, ifc.md_a, ifc.md_b);
        end else if (bcnt != 4'd0) begin
            bcnt <= bcnt - 4'd1;
        end
    end

    always @(posedge clk) begin
        if (reset && bcnt == 4'd1) {hi, lo} <= pend;
        if (ifc.md_mthi) hi <= ifc.md_a;
        if (ifc.md_mtlo) lo <= ifc.md_a;
    end

    typedef struct {
        logic        v;
        logic [2:0]  op;
        logic        mthi, mtlo, mfhi, mflo, flush;
        logic [31:0] rs, rt;
        logic        x_start, x_mthi, x_mtlo;
        logic [31:0] x_mf;
        logic        x_err;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [2:0] op, input logic mthi, input logic mtlo,
                                input logic mfhi, input logic mflo, input logic flush,
                                input logic [31:0] rs, input logic [31:0] rt,
                                input logic xs, input logic xhi, input logic xlo,
                                input logic [31:0] xmf, input logic xerr);
        vec_t t;
        t.v = v; t.op = op; t.mthi = mthi; t.mtlo = mtlo; t.mfhi = mfhi; t.mflo = mflo; t.flush = flush;
        t.rs = rs; t.rt = rt; t.x_start = xs; t.x_mthi = xhi; t.x_mtlo = xlo; t.x_mf = xmf; t.x_err = xerr;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        ifc.e_md_valid = t.v;
        ifc.e_md_op    = t.op;
        ifc.e_mthi     = t.mthi;
        ifc.e_mtlo     = t.mtlo;
        ifc.e_mfhi     = t.mfhi;
        ifc.e_mflo     = t.mflo;
        ifc.flush      = t.flush;
        ifc.e_rs       = t.rs;
        ifc.e_rt       = t.rt;
    endtask

    vec_t nil;

    // Clears inputs, waits out busy, then lands one cycle later with the FSM settled.
    task automatic wait_idle(input string nm);
        @(negedge clk);
        apply(nil);
        for (int i = 0; i < 40; i++) begin
            if (!ifc.md_busy) break;
            @(negedge clk);
        end
        if (ifc.md_busy) begin
            tests++;
            fails++;
            $display("FAIL %s: busy still high after 40 cycles", nm);
        end
        @(negedge clk);
    endtask

    // Holds `nx` in E each cycle and counts stalled cycles until it gets through.
    task automatic count_stall(input vec_t nx, input int flush_at, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            apply(nx);
            ifc.flush = (i == flush_at);
            #1;
            if (i == flush_at) chk("flush_in_stall", {62'd0, ifc.md_start, ifc.stall_e}, 64'd1);
            if (!ifc.stall_e) return;
            n++;
        end
        tests++;
        fails++;
        $display("FAIL stall_bound: stall still high after 40 cycles");
    endtask

    vec_t tbl[18];
    int   n;

    initial begin
        nil = mk(0, 3'd0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 0, 0, 0, 32'd0, 0);
        //           v  op        hi lo fh fl fl  rs             rt            st th tl mf             err
        tbl[0]  = mk(1, OP_MULT,  0, 0, 0, 0, 0, 32'd7,         32'hFFFF_FFFD, 1, 0, 0, 32'd0,         0);
        tbl[1]  = mk(0, 3'd0,     0, 0, 0, 1, 0, 32'd0,         32'd0,         0, 0, 0, 32'hFFFF_FFEB, 0);
        tbl[2]  = mk(0, 3'd0,     0, 0, 1, 0, 0, 32'd0,         32'd0,         0, 0, 0, 32'hFFFF_FFFF, 0);
        tbl[3]  = mk(0, 3'd0,     1, 0, 0, 0, 0, 32'hDEAD_BEEF, 32'd0,         0, 1, 0, 32'd0,         0);
        tbl[4]  = mk(0, 3'd0,     0, 0, 1, 0, 0, 32'd0,         32'd0,         0, 0, 0, 32'hDEAD_BEEF, 0);
        tbl[5]  = mk(0, 3'd0,     0, 1, 0, 0, 0, 32'h1234_5678, 32'd0,         0, 0, 1, 32'd0,         0);
        tbl[6]  = mk(0, 3'd0,     0, 0, 0, 1, 0, 32'd0,         32'd0,         0, 0, 0, 32'h1234_5678, 0);
        tbl[7]  = mk(1, OP_MULT,  0, 0, 0, 0, 1, 32'd2,         32'd3,         0, 0, 0, 32'd0,         0);
        tbl[8]  = mk(0, 3'd0,     0, 0, 0, 1, 0, 32'd0,         32'd0,         0, 0, 0, 32'h1234_5678, 0);
        tbl[9]  = mk(1, OP_DIVU,  0, 0, 0, 0, 0, 32'd100,       32'd7,         1, 0, 0, 32'd0,         0);
        tbl[10] = mk(0, 3'd0,     0, 0, 0, 1, 0, 32'd0,         32'd0,         0, 0, 0, 32'd14,        0);
        tbl[11] = mk(0, 3'd0,     0, 0, 1, 0, 0, 32'd0,         32'd0,         0, 0, 0, 32'd2,         0);
        tbl[12] = mk(1, OP_MULTU, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'd2,         1, 0, 0, 32'd0,         0);
        tbl[13] = mk(0, 3'd0,     0, 0, 1, 0, 0, 32'd0,         32'd0,         0, 0, 0, 32'd1,         0);
        tbl[14] = mk(0, 3'd0,     1, 0, 0, 0, 1, 32'd55,        32'd0,         0, 0, 0, 32'd0,         0);
        tbl[15] = mk(0, 3'd0,     0, 0, 1, 0, 0, 32'd0,         32'd0,         0, 0, 0, 32'd1,         0);
        tbl[16] = mk(1, OP_DIV,   0, 0, 0, 0, 0, 32'hFFFF_FFF9, 32'd2,         1, 0, 0, 32'd0,         0);
        tbl[17] = mk(1, 3'd6,     0, 0, 0, 1, 0, 32'd0,         32'd0,         0, 0, 0, 32'hFFFF_FFFD, 1);

        // Reset: strobes suppressed even with a request present
        apply(tbl[0]);
        ifc.e_mthi = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_start", {63'd0, ifc.md_start}, 64'd0);
        chk("rst_mthi",  {63'd0, ifc.md_mthi},  64'd0);
        chk("rst_stall", {63'd0, ifc.stall_e},  64'd0);
        chk("rst_err",   {63'd0, ifc.md_err},   64'd0);
        apply(nil);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            apply(tbl[i]);
            #1;
            chk($sformatf("v%0d_start", i), {63'd0, ifc.md_start}, {63'd0, tbl[i].x_start});
            chk($sformatf("v%0d_mthi",  i), {63'd0, ifc.md_mthi},  {63'd0, tbl[i].x_mthi});
            chk($sformatf("v%0d_mtlo",  i), {63'd0, ifc.md_mtlo},  {63'd0, tbl[i].x_mtlo});
            chk($sformatf("v%0d_stall", i), {63'd0, ifc.stall_e},  64'd0);
            chk($sformatf("v%0d_mf",    i), {32'd0, ifc.mf_data},  {32'd0, tbl[i].x_mf});
            chk($sformatf("v%0d_pass",  i), {ifc.md_op, ifc.md_a, ifc.md_b[28:0]},
                                            {tbl[i].op, tbl[i].rs, tbl[i].rt[28:0]});
            wait_idle($sformatf("v%0d_idle", i));
            chk($sformatf("v%0d_err", i), {63'd0, ifc.md_err}, {63'd0, tbl[i].x_err});
        end

        // Clear sticky error
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("err_clear", {63'd0, ifc.md_err}, 64'd0);
        reset = 1'b1;

        // mult 7*-3 then mflo held behind it
        @(negedge clk);
        apply(tbl[0]);
        #1;
        chk("A_start", {63'd0, ifc.md_start}, 64'd1);
        count_stall(tbl[1], -1, n);
        chk("A_stall_cycles", n, 5);
        chk("A_mf",    {32'd0, ifc.mf_data}, {32'd0, 32'hFFFF_FFEB});
        chk("A_hi",    {32'd0, ifc.md_hi},   {32'd0, 32'hFFFF_FFFF});
        chk("A_start_once", {63'd0, ifc.md_start}, 64'd0);
        wait_idle("A_idle");
        chk("A_err", {63'd0, ifc.md_err}, 64'd0);

        // divu 100/7 with multu 3*5 back-to-back, flush poked mid-stall
        @(negedge clk);
        apply(tbl[9]);
        #1;
        chk("B_start", {63'd0, ifc.md_start}, 64'd1);
        count_stall(mk(1, OP_MULTU, 0, 0, 0, 0, 0, 32'd3, 32'd5, 0, 0, 0, 0, 0), 3, n);
        chk("B_stall_cycles", n, 10);
        chk("B_issue_on_fall", {63'd0, ifc.md_start}, 64'd1);
        chk("B_hilo", {ifc.md_hi, ifc.md_lo}, {32'd2, 32'd14});
        wait_idle("B_idle");
        chk("B_err", {63'd0, ifc.md_err}, 64'd0);
        apply(tbl[1]);
        #1;
        chk("B_multu_lo", {32'd0, ifc.mf_data}, 64'd15);
        apply(nil);

        // Short busy (4 cycles) on mult: sticky error
        lat_ov = 4;
        @(negedge clk);
        apply(tbl[0]);
        wait_idle("C_idle");
        chk("C_err", {63'd0, ifc.md_err}, 64'd1);
        repeat (3) @(negedge clk);
        chk("C_err_sticky", {63'd0, ifc.md_err}, 64'd1);
        lat_ov = 0;

        // Reset asserted in the first RUN cycle: straight back to IDLE, error cleared
        apply(tbl[0]);
        #1;
        chk("C_run_start", {63'd0, ifc.md_start}, 64'd1);
        @(negedge clk);
        ifc.e_mflo = 1'b1;
        #1;
        chk("C_run_stall", {63'd0, ifc.stall_e}, 64'd1);
        reset = 1'b0;
        #1;
        chk("C_rst_stall", {63'd0, ifc.stall_e}, 64'd0);
        chk("C_rst_start", {63'd0, ifc.md_start}, 64'd0);
        chk("C_rst_err",   {63'd0, ifc.md_err},   64'd0);
        @(negedge clk);
        apply(nil);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("C_post_busy", {63'd0, ifc.md_busy}, 64'd0);
        chk("C_post_err",  {63'd0, ifc.md_err},  64'd0);

        // div by zero
        @(negedge clk);
        apply(mk(1, OP_DIV, 0, 0, 0, 0, 0, 32'd5, 32'd0, 0, 0, 0, 0, 0));
        #1;
`ifdef MD_DIV0_SKIP_EN
        chk("D_start", {63'd0, ifc.md_start}, 64'd0);
        count_stall(tbl[1], -1, n);
        chk("D_stall_cycles", n, 0);
`else
        chk("D_start", {63'd0, ifc.md_start}, 64'd1);
        count_stall(tbl[1], -1, n);
        chk("D_stall_cycles", n, 10);
`endif
        wait_idle("D_idle");
        chk("D_err", {63'd0, ifc.md_err}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
